// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the cache-line SRAM arbiter.
// Line geometry, FSM encoding and the latched request bundle.
package sram_arb_pkg;

  localparam int LINE_BITS = 512;
  localparam int DM_BITS   = 64;
  localparam int LINE_OFS  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]          addr;
    logic [LINE_BITS-1:0] din;
    logic [DM_BITS-1:0]   dm;
    logic                 we;
  } line_req_t;

  function automatic logic [31:0] line_align(
    input logic [31:0] a
  );
    logic [31:0] mask;
    mask = (32'd1 << LINE_OFS) - 32'd1;
    return a & ~mask;
  endfunction

endpackage

// File: rtl/sram_line_arbiter_rr.sv
// Two-input grant logic with a last-grant pointer.
// Round-robin on ties unless FIXED_PRIO pins requester 0.
module sram_arb_rr
  import sram_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clkCPU,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic last;

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clkCPU or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= upd_idx;
    end
  end

  // Pick the winner from the current request pair.
  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    unique case (1'b1)
      (req == 2'b11): begin
        gnt_idx = (FIXED_PRIO != 0) ? 1'b0 : ~last;
      end
      (req == 2'b10): begin
        gnt_idx = 1'b1;
      end
      default: begin
        gnt_idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sram_line_arbiter.sv
// Arbiter sequencing one 512-bit line transaction at a time
// from the D-cache (m0) and I-cache (m1) into the SRAM wrapper.
module sram_line_arbiter
  import sram_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 clkCPU,
  input  logic                 rst_n,
  input  logic [31:0]          m0_addr,
  input  logic [LINE_BITS-1:0] m0_din,
  input  logic [DM_BITS-1:0]   m0_dm,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  output logic                 m0_ack,
  output logic [LINE_BITS-1:0] m0_dout,
  input  logic [31:0]          m1_addr,
  input  logic [LINE_BITS-1:0] m1_din,
  input  logic [DM_BITS-1:0]   m1_dm,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  output logic                 m1_ack,
  output logic [LINE_BITS-1:0] m1_dout,
  output logic [31:0]          s_addr,
  output logic [LINE_BITS-1:0] s_din,
  output logic [DM_BITS-1:0]   s_dm,
  output logic                 s_stb,
  output logic                 s_we,
  input  logic                 s_ack,
  input  logic [LINE_BITS-1:0] s_dout,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [9:0] TO_LIM = 10'(TIMEOUT);

  state_t    state;
  logic      gnt;
  logic [9:0] wcnt;
  logic [9:0] wcnt_inc;
  logic      gnt_vld;
  logic      gnt_idx;
  logic      rr_upd;
  line_req_t req_m0;
  line_req_t req_m1;
  line_req_t pick;

  assign req_m0 = {m0_addr, m0_din, m0_dm, m0_we};
  assign req_m1 = {m1_addr, m1_din, m1_dm, m1_we};
  assign pick   = gnt_idx ? req_m1 : req_m0;

  assign rr_upd   = (state == WAIT) && s_ack;
  assign wcnt_inc = (wcnt == TO_LIM) ? wcnt
                                     : wcnt + 10'd1;
  assign busy     = (state != IDLE);

  sram_arb_rr #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rr (
    .clkCPU (clkCPU),
    .rst_n  (rst_n),
    .req    ({m1_stb, m0_stb}),
    .upd    (rr_upd),
    .upd_idx(gnt),
    .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx)
  );

  // Transaction sequencer; strobe is a single-cycle pulse so the
  // wrapper cannot re-trigger after its ack.
  always_ff @(posedge clkCPU or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      wcnt        <= 10'd0;
      s_addr      <= '0;
      s_din       <= '0;
      s_dm        <= '0;
      s_stb       <= 1'b0;
      s_we        <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_dout     <= '0;
      m1_dout     <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            s_addr <= line_align(pick.addr);
            s_din  <= pick.din;
            s_dm   <= pick.dm;
            s_we   <= pick.we;
            s_stb  <= 1'b1;
            gnt    <= gnt_idx;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          s_stb <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          wcnt <= wcnt_inc;
          if (wcnt_inc == TO_LIM) begin
            timeout_err <= 1'b1;
          end
          if (s_ack) begin
            if (!s_we) begin
              if (gnt) begin
                m1_dout <= s_dout;
              end else begin
                m0_dout <= s_dout;
              end
            end
            if (gnt) begin
              m1_ack <= 1'b1;
            end else begin
              m0_ack <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          wcnt   <= 10'd0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_line_arbiter.sv
// Bench for sram_line_arbiter: two instances (round-robin with a
// short watchdog, fixed priority) checked against a timing model.
module tb_sram_line_arbiter;

  logic clkCPU = 1'b0;
  logic rst_n;
  always #5 clkCPU = ~clkCPU;

  logic [31:0]  ma   [2][2];
  logic [511:0] mdi  [2][2];
  logic [63:0]  mdm  [2][2];
  logic         mstb [2][2];
  logic         mwe  [2][2];
  logic         mack [2][2];
  logic [511:0] mdo  [2][2];
  logic [31:0]  sa   [2];
  logic [511:0] sdi  [2];
  logic [63:0]  sdm  [2];
  logic         sstb [2];
  logic         swe  [2];
  logic         wack [2];
  logic         stray[2];
  logic         sack [2];
  logic [511:0] sdo  [2];
  logic         busy [2];
  logic         terr [2];

  assign sack[0] = wack[0] | stray[0];
  assign sack[1] = wack[1] | stray[1];

  sram_line_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8)) u_rr (
    .clkCPU(clkCPU), .rst_n(rst_n),
    .m0_addr(ma[0][0]), .m0_din(mdi[0][0]), .m0_dm(mdm[0][0]),
    .m0_stb(mstb[0][0]), .m0_we(mwe[0][0]),
    .m0_ack(mack[0][0]), .m0_dout(mdo[0][0]),
    .m1_addr(ma[0][1]), .m1_din(mdi[0][1]), .m1_dm(mdm[0][1]),
    .m1_stb(mstb[0][1]), .m1_we(mwe[0][1]),
    .m1_ack(mack[0][1]), .m1_dout(mdo[0][1]),
    .s_addr(sa[0]), .s_din(sdi[0]), .s_dm(sdm[0]),
    .s_stb(sstb[0]), .s_we(swe[0]),
    .s_ack(sack[0]), .s_dout(sdo[0]),
    .busy(busy[0]), .timeout_err(terr[0])
  );

  sram_line_arbiter #(.FIXED_PRIO(1), .TIMEOUT(1023)) u_fp (
    .clkCPU(clkCPU), .rst_n(rst_n),
    .m0_addr(ma[1][0]), .m0_din(mdi[1][0]), .m0_dm(mdm[1][0]),
    .m0_stb(mstb[1][0]), .m0_we(mwe[1][0]),
    .m0_ack(mack[1][0]), .m0_dout(mdo[1][0]),
    .m1_addr(ma[1][1]), .m1_din(mdi[1][1]), .m1_dm(mdm[1][1]),
    .m1_stb(mstb[1][1]), .m1_we(mwe[1][1]),
    .m1_ack(mack[1][1]), .m1_dout(mdo[1][1]),
    .s_addr(sa[1]), .s_din(sdi[1]), .s_dm(sdm[1]),
    .s_stb(sstb[1]), .s_we(swe[1]),
    .s_ack(sack[1]), .s_dout(sdo[1]),
    .busy(busy[1]), .timeout_err(terr[1])
  );

  int n_run = 0;
  int n_fail = 0;

  function automatic void chk(input string nm,
                              input logic [511:0] act,
                              input logic [511:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  localparam int PRIO [2] = '{0, 1};
  localparam int TOV  [2] = '{8, 1023};

  int           cyc;
  bit           inf   [2];
  bit           acked [2];
  int           t_iss [2];
  int           t_ack [2];
  int           wc_m  [2];
  bit           w     [2];
  bit           last  [2];
  bit           err   [2];
  logic [31:0]  ea    [2];
  logic [511:0] edi   [2];
  logic [63:0]  edm   [2];
  bit           ewe   [2];
  logic [511:0] edo   [2][2];

  function automatic void mreset();
    for (int d = 0; d < 2; d++) begin
      inf[d] = 0; acked[d] = 0; wc_m[d] = 0;
      last[d] = 1; err[d] = 0; w[d] = 0;
      edo[d][0] = '0; edo[d][1] = '0;
    end
  endfunction

  // e is the cycle that the current clock edge ends.
  function automatic void mstep(input int d, input int e);
    if (inf[d]) begin
      if (!acked[d] && e > t_iss[d]) begin
        if (wc_m[d] < TOV[d]) wc_m[d]++;
        if (wc_m[d] >= TOV[d]) err[d] = 1;
        if (sack[d]) begin
          acked[d] = 1;
          t_ack[d] = e + 1;
          last[d]  = w[d];
          if (!ewe[d]) edo[d][w[d]] = sdo[d];
        end
      end else if (acked[d] && e == t_ack[d]) begin
        inf[d] = 0;
      end
    end else if (mstb[d][0] || mstb[d][1]) begin
      if (mstb[d][0] && mstb[d][1])
        w[d] = (PRIO[d] != 0) ? 1'b0 : !last[d];
      else
        w[d] = mstb[d][1];
      ea[d]  = ma[d][w[d]] & 32'hFFFF_FFC0;
      edi[d] = mdi[d][w[d]];
      edm[d] = mdm[d][w[d]];
      ewe[d] = mwe[d][w[d]];
      inf[d] = 1; acked[d] = 0; wc_m[d] = 0;
      t_iss[d] = e + 1;
    end
  endfunction

  initial begin
    cyc = 0;
    mreset();
    forever begin
      @(posedge clkCPU or negedge rst_n);
      if (!rst_n) begin
        mreset();
      end else begin
        for (int d = 0; d < 2; d++) mstep(d, cyc);
        cyc++;
      end
    end
  end

  // Compare every output of both instances mid-cycle.
  initial begin
    forever begin
      @(negedge clkCPU);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d busy", d), busy[d], inf[d]);
        chk($sformatf("d%0d s_stb", d), sstb[d],
            inf[d] && cyc == t_iss[d]);
        for (int r = 0; r < 2; r++) begin
          chk($sformatf("d%0d m%0d_ack", d, r), mack[d][r],
              inf[d] && acked[d] && cyc == t_ack[d] && w[d] == r);
          chk($sformatf("d%0d m%0d_dout", d, r), mdo[d][r],
              edo[d][r]);
        end
        chk($sformatf("d%0d timeout_err", d), terr[d], err[d]);
        if (inf[d]) begin
          chk($sformatf("d%0d s_addr", d), sa[d], ea[d]);
          chk($sformatf("d%0d s_din", d), sdi[d], edi[d]);
          chk($sformatf("d%0d s_dm", d), sdm[d], edm[d]);
          chk($sformatf("d%0d s_we", d), swe[d], ewe[d]);
        end
      end
    end
  end

  // ---------------- wrapper model ----------------
  int           lat [2];
  logic [511:0] rdl [2];
  int           wc  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      wc[d] = 0; wack[d] = 0; sdo[d] = '0;
    end
    forever begin
      @(posedge clkCPU);
      #1;
      for (int d = 0; d < 2; d++) begin
        wack[d] = 0;
        if (!rst_n) begin
          wc[d] = 0;
        end else begin
          if (wc[d] > 0) begin
            wc[d]--;
            if (wc[d] == 0) wack[d] = 1;
          end
          if (sstb[d]) wc[d] = lat[d];
        end
        sdo[d] = wack[d] ? rdl[d] : ~rdl[d];
      end
    end
  end

  // ---------------- requester side ----------------
  int           mcyc;
  int           acks   [2][2];
  int           rem    [2][2];
  bit           drop   [2][2];
  int           order  [2][$];
  int           stb_n  [2];
  int           stb_at [2];
  int           sack_at[2];
  int           ack_at [2];
  int           err_at [2];
  logic [31:0]  sa_c   [2];
  logic [511:0] sdi_c  [2];
  logic [63:0]  sdm_c  [2];
  logic         swe_c  [2];

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      order[d].delete();
      stb_n[d] = 0; stb_at[d] = -1; sack_at[d] = -1;
      ack_at[d] = -1; err_at[d] = -1;
      for (int r = 0; r < 2; r++) acks[d][r] = 0;
    end
  endtask

  task automatic step();
    @(posedge clkCPU);
    #2;
    mcyc++;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (drop[d][r]) begin
          mstb[d][r] = 0;
          drop[d][r] = 0;
        end
        if (mack[d][r]) begin
          acks[d][r]++;
          order[d].push_back(r);
          rem[d][r]--;
          if (rem[d][r] <= 0) drop[d][r] = 1;
          else ma[d][r] = ma[d][r] + 32'h40;
        end
      end
      if (sstb[d]) begin
        stb_n[d]++; stb_at[d] = mcyc;
        sa_c[d] = sa[d]; sdi_c[d] = sdi[d];
        sdm_c[d] = sdm[d]; swe_c[d] = swe[d];
      end
      if (sack[d]) sack_at[d] = mcyc;
      if (mack[d][0] || mack[d][1]) ack_at[d] = mcyc;
      if (terr[d] && err_at[d] < 0) err_at[d] = mcyc;
    end
  endtask

  task automatic req(input int d, input int r,
                     input logic [31:0] a,
                     input logic [511:0] din,
                     input logic [63:0] dm,
                     input logic we, input int n);
    ma[d][r] = a; mdi[d][r] = din; mdm[d][r] = dm;
    mwe[d][r] = we; rem[d][r] = n; mstb[d][r] = 1;
  endtask

  task automatic clear_reqs();
    for (int d = 0; d < 2; d++) begin
      stray[d] = 0;
      for (int r = 0; r < 2; r++) begin
        mstb[d][r] = 0; rem[d][r] = 0; drop[d][r] = 0;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    bit pend;
    i = 0;
    do begin
      step();
      i++;
      pend = busy[0] | busy[1];
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 2; r++)
          if (rem[d][r] > 0 || drop[d][r]) pend = 1;
    end while (pend && i < budget);
    chk({nm, " completes in budget"}, pend, 1'b0);
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    clear_reqs();
    step();
    step();
    rst_n = 1;
  endtask

  int exp_o [4];

  initial begin
    rst_n = 0;
    mcyc = 0;
    for (int d = 0; d < 2; d++) begin
      lat[d] = 2; rdl[d] = {16{32'h0BAD_F00D}};
      for (int r = 0; r < 2; r++) begin
        ma[d][r] = '0; mdi[d][r] = '0;
        mdm[d][r] = '0; mwe[d][r] = 0;
      end
    end
    clear_reqs();
    clear_stats();
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst d%0d busy", d), busy[d], 0);
      chk($sformatf("rst d%0d terr", d), terr[d], 0);
      chk($sformatf("rst d%0d s_stb", d), sstb[d], 0);
      chk($sformatf("rst d%0d s_addr", d), sa[d], 0);
      chk($sformatf("rst d%0d m0_dout", d), mdo[d][0], 0);
      chk($sformatf("rst d%0d m1_ack", d), mack[d][1], 0);
    end
    rst_n = 1;
    step();

    // single read, 18-cycle wrapper latency
    clear_stats();
    lat[0] = 18;
    rdl[0] = {16{32'hA5A5_A5A5}};
    req(0, 0, 32'h0000_1044, {16{32'hDEAD_BEEF}},
        64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
    wait_idle(80, "read");
    chk("read s_addr aligned", sa_c[0], 32'h0000_1040);
    chk("read s_stb cycles", stb_n[0], 1);
    chk("read ack latency", sack_at[0] - stb_at[0], 18);
    chk("read m0_ack after s_ack", ack_at[0] - sack_at[0], 1);
    chk("read m0_dout", mdo[0][0], {16{32'hA5A5_A5A5}});
    chk("read m0 ack count", acks[0][0], 1);
    chk("read m1 ack count", acks[0][1], 0);
    chk("read long wait sets err", terr[0], 1);
    reset_pulse();
    chk("err cleared by reset", terr[0], 0);

    // write from m1
    clear_stats();
    lat[0] = 3;
    req(0, 1, 32'h0000_2000, {16{32'h1234_5678}},
        64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
    wait_idle(40, "write");
    chk("write s_we", swe_c[0], 1);
    chk("write s_dm", sdm_c[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("write s_din", sdi_c[0], {16{32'h1234_5678}});
    chk("write s_addr", sa_c[0], 32'h0000_2000);
    chk("write m1_ack after s_ack", ack_at[0] - sack_at[0], 1);
    chk("write m1 ack count", acks[0][1], 1);
    chk("write m1_dout untouched", mdo[0][1], 0);
    chk("write m0 ack count", acks[0][0], 0);

    // round-robin contention
    clear_stats();
    lat[0] = 2;
    rdl[0] = {16{32'h5A5A_0F0F}};
    req(0, 0, 32'h0000_3000, '0, '0, 1'b0, 2);
    req(0, 1, 32'h0000_4000, '0, '0, 1'b0, 2);
    wait_idle(120, "rr");
    exp_o = '{0, 1, 0, 1};
    chk("rr grant count", order[0].size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < order[0].size())
        chk($sformatf("rr grant %0d", k), order[0][k], exp_o[k]);
    chk("rr m0 acks", acks[0][0], 2);
    chk("rr m1 acks", acks[0][1], 2);

    // watchdog
    reset_pulse();
    clear_stats();
    lat[0] = 20;
    req(0, 0, 32'h0000_5000, '0, '0, 1'b0, 1);
    wait_idle(80, "timeout");
    chk("timeout err cycle", err_at[0] - stb_at[0], 9);
    chk("timeout ack latency", sack_at[0] - stb_at[0], 20);
    chk("timeout still acks", acks[0][0], 1);
    step(); step(); step();
    chk("timeout err sticky", terr[0], 1);
    reset_pulse();
    chk("timeout err reset", terr[0], 0);

    // fixed priority
    clear_stats();
    lat[1] = 2;
    req(1, 0, 32'h0000_6000, '0, '0, 1'b0, 3);
    req(1, 1, 32'h0000_7000, '0, '0, 1'b0, 1);
    wait_idle(120, "fixed");
    exp_o = '{0, 0, 0, 1};
    chk("fixed grant count", order[1].size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < order[1].size())
        chk($sformatf("fixed grant %0d", k), order[1][k], exp_o[k]);

    // reset during WAIT, then a stray ack
    clear_stats();
    lat[0] = 30;
    req(0, 0, 32'h0000_8000, {16{32'h0000_FFFF}},
        '1, 1'b0, 1);
    repeat (6) step();
    chk("midwait busy", busy[0], 1);
    rst_n = 0;
    clear_reqs();
    #1;
    chk("midreset busy", busy[0], 0);
    chk("midreset s_stb", sstb[0], 0);
    chk("midreset s_addr", sa[0], 0);
    chk("midreset s_din", sdi[0], 0);
    chk("midreset s_dm", sdm[0], 0);
    chk("midreset s_we", swe[0], 0);
    chk("midreset m0_ack", mack[0][0], 0);
    chk("midreset m0_dout", mdo[0][0], 0);
    chk("midreset terr", terr[0], 0);
    step();
    step();
    rst_n = 1;
    step();
    stray[0] = 1;
    step();
    stray[0] = 0;
    repeat (4) step();
    chk("stray no m0_ack", acks[0][0], 0);
    chk("stray no m1_ack", acks[0][1], 0);
    chk("stray no err", terr[0], 0);
    chk("stray idle", busy[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/sram_line_arbiter.md
Name: sram_line_arbiter

Overview:
- Two-requester arbiter in front of the 512-bit cache-line SRAM Wishbone slave wrapper.
- Requester 0 is the D-cache refill/writeback port; requester 1 is the I-cache refill port.
- Sequences exactly one line transaction at a time into the wrapper and captures the read line.
- Returns a one-cycle ack to the winner. Flags a watchdog error if the SRAM side stalls.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins ties.
- TIMEOUT, 1023, WAIT-state cycle limit before timeout_err sets; 10-bit counter.

Ports:
- clkCPU  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_addr  in  32  requester 0 byte address
- m0_din  in  512  requester 0 write line
- m0_dm  in  64  requester 0 byte enables
- m0_stb  in  1  requester 0 request, held until m0_ack
- m0_we  in  1  requester 0 write
- m0_ack  out  1  requester 0 completion pulse
- m0_dout  out  512  requester 0 read line
- m1_* (addr, din, dm, stb, we, ack, dout)  same widths and meanings for requester 1
- s_addr  out  32  to wrapper ws_addr
- s_din  out  512  to wrapper ws_din
- s_dm  out  64  to wrapper ws_dm
- s_stb  out  1  to wrapper ws_stb
- s_we  out  1  to wrapper ws_we
- s_ack  in  1  from wrapper ws_ack, one-cycle pulse
- s_dout  in  512  from wrapper ws_dout, valid only in the s_ack cycle
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values (rst_n low, asynchronous):
  - State IDLE.
  - All s_*, m*_ack, busy and timeout_err are 0.
  - m*_dout are 0. Last-grant pointer is 1, so requester 0 wins first.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitration runs on m0_stb and m1_stb.
  - Single request: that requester wins.
  - Both requesting with FIXED_PRIO=0: the requester not granted last wins.
  - Both requesting with FIXED_PRIO=1: requester 0 wins.
  - On the edge with any winner: latch the winner's addr, din, dm and we into s_*. Force s_addr[5:0]=0 (64-byte line alignment). Record the grant. Go to ISSUE.
- ISSUE:
  - s_stb=1 for exactly one cycle, then go to WAIT.
  - The wrapper samples stb only when it is ready, so a single-cycle strobe prevents a re-trigger after its ack.
- WAIT:
  - s_stb=0; s_addr, s_din, s_dm and s_we are held stable.
  - On s_ack=1: capture s_dout into the granted requester's m*_dout (reads only; writes leave m*_dout unchanged), update the last-grant pointer, go to DONE.
  - The wait counter increments each WAIT cycle, saturating at TIMEOUT.
  - Reaching TIMEOUT sets timeout_err, which stays set until reset. The transaction is not aborted; WAIT persists until s_ack.
- DONE:
  - Granted requester's m*_ack=1 for one cycle; go to IDLE. The counter clears.
- Latency:
  - Request seen at edge t gives s_stb high in cycle t+1.
  - s_ack seen at edge k gives m*_ack high in cycle k+1.
  - Minimum issue-to-next-issue gap: 3 cycles after s_ack.
- Requester contract:
  - stb is held with stable address and data until ack.
  - stb drops on the edge that samples ack=1, so IDLE after DONE does not see the stale request.
- m*_dout is held until that requester's next read completes.
- The losing requester is untouched, with no ack; its request is served next under round-robin.
- s_ack arriving in IDLE, ISSUE or DONE is ignored. It does not set timeout_err.
- Reset asserted mid-transaction: immediate return to IDLE with outputs cleared. The wrapper is assumed reset by the same rst_n domain.

Decomposition:
- Shared package sram_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3;
  - LINE_BITS=512, DM_BITS=64, LINE_OFS=6.
- One sub-module, sram_arb_rr: two-input round-robin/fixed-priority grant logic with the last-grant pointer update input.

Test Plan:
- Single read: m0 requests read at 0x0000_1044, wrapper model returns a line of 0xA5A5A5A5 words with ack 18 cycles after s_stb.
  - Required: s_addr=0x0000_1040, s_stb high exactly 1 cycle.
  - Required: m0_ack 1 cycle after s_ack, with m0_dout equal to the line; m1_ack stays 0.
- Write: m1 writes din=all 0x12345678 words, dm=64'hFFFF_FFFF_FFFF_FFFF.
  - Required: s_we=1, s_dm and s_din match, m1_ack after s_ack.
  - Required: m1_dout unchanged (still 0 after reset).
- Contention with FIXED_PRIO=0: m0 and m1 assert in the same cycle, three times back-to-back.
  - Required grant order: m0, m1, m0; each gets exactly one ack per request.
- Contention with FIXED_PRIO=1: both assert continuously.
  - Required: m0 wins every arbitration while m0_stb re-asserts; m1 is served only in a cycle where m0_stb=0.
- Timeout: TIMEOUT=8, wrapper withholds ack for 20 cycles.
  - Required: timeout_err rises after the 8th WAIT cycle; ack still completes normally; flag stays 1 until rst_n low.
- Reset mid-WAIT: assert rst_n=0 during WAIT.
  - Required: all outputs 0 and busy=0 immediately.
  - Required: a stray s_ack after release produces no m*_ack.
